mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer for the MEM stage of the five-stage pipeline when data memory has variable latency. It accepts a load or store from the EX/MEM register and runs a req/ack transaction on the data-memory port. While the transaction is in flight it stalls the upstream pipeline registers and injects bubbles into the MEM/WB register. It delivers load data to the MEM/WB input and flags a sticky fault if memory never answers.

## Interface
- TIMEOUT, 16, max ACCESS cycles without ack before fault; legal range 1..255
- clk  in  1  pipeline clock, all state on posedge
- reset  in  1  synchronous, active-high
- MemReadMEM  in  1  load in MEM stage (from EX/MEM)
- MemWriteMEM  in  1  store in MEM stage (from EX/MEM)
- AddrMEM  in  32  byte address (ALU result)
- WriteDataMEM  in  32  store data
- dmem_req  out  1  request to data memory, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  32  registered address
- dmem_wdata  out  32  registered write data
- dmem_ack  in  1  single-cycle completion strobe from memory
- dmem_rdata  in  32  read data, valid when dmem_ack=1
- ReadDataMEM  out  32  load result to MEM/WB, registered
- StallPipe  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- BubbleWB  out  1  MEM/WB must capture RegWrite=0, MemtoReg=0
- MemFault  out  1  sticky timeout flag

## Operation
- States: IDLE, ACCESS, DONE.
- Op present = MemReadMEM | MemWriteMEM. If both bits are set, the op is a store; the read is ignored.
- IDLE, no op: StallPipe=0; remain IDLE.
- IDLE, op present: StallPipe=1 combinationally. At the edge:
  - capture AddrMEM to dmem_addr and WriteDataMEM to dmem_wdata;
  - set dmem_we=MemWriteMEM and dmem_req=1;
  - clear the wait counter;
  - move to ACCESS.
- ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable; StallPipe=1.
  - If dmem_ack=1: for a read, capture dmem_rdata to ReadDataMEM. Clear dmem_req and dmem_we, then move to DONE.
  - Else if counter==TIMEOUT-1: set MemFault=1, set ReadDataMEM=0 for a read, clear req/we, move to DONE.
  - Else: increment the counter.
  - If ack arrives on the final allowed cycle, ack wins and no fault is raised.
- DONE: StallPipe=0, so MEM/WB captures the completed instruction at this edge. Always move to IDLE.
- BubbleWB == StallPipe at all times.
- dmem_ack is ignored in IDLE and DONE.
- Stores leave ReadDataMEM unchanged.
- dmem_addr and dmem_wdata keep their last values outside ACCESS.
- MemFault clears only on reset; operation continues normally after a fault.
- Counter is 8 bits.

## Timing
- Reset values: state IDLE; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, ReadDataMEM=0, MemFault=0, counter=0.
- StallPipe and BubbleWB are forced to 0 while reset=1.
- Op enters MEM in cycle t:
  - stall in t;
  - dmem_req high from t+1;
  - with ack in cycle t+1+w, DONE in t+2+w;
  - total stall is 2+w cycles;
  - minimum 2 stall cycles (w=0).
- ReadDataMEM is valid from the first DONE cycle and holds until the next read completes.
- Reset during ACCESS: at the next edge dmem_req=0, state IDLE, no fault. ReadDataMEM returns to 0. A late ack after reset is ignored.
- Back-to-back memory ops: DONE→IDLE, then the next op stalls immediately. There is no overlap of transactions.
- Timeout: dmem_req is high for exactly TIMEOUT cycles. MemFault rises at the same edge that req falls.

## Test plan
- Reset sequence: hold reset 2 cycles with dmem_ack toggling. Required: all outputs 0, StallPipe=0, no req.
- Zero-wait load: MemReadMEM=1, AddrMEM=0x100 at t; ack at t+1 with rdata=0x12345678. Required:
  - dmem_req high only in t+1, dmem_addr=0x100;
  - StallPipe high t..t+1;
  - ReadDataMEM=0x12345678 and StallPipe=0 in t+2.
- Store with 3-cycle wait: MemWriteMEM=1, AddrMEM=0x200, WriteDataMEM=0xCAFEF00D; ack at t+4. Required:
  - dmem_req/we high t+1..t+4 with address and data stable;
  - StallPipe 5 cycles;
  - ReadDataMEM unchanged.
- Load immediately followed by store, both acked at zero wait, and a case with both Read and Write set. Required: two separate transactions with 2 stall cycles each; the dual-bit op issues dmem_we=1.
- Timeout with TIMEOUT=4 and no ack on a load. Required:
  - dmem_req high exactly 4 cycles;
  - MemFault=1 and ReadDataMEM=0 thereafter;
  - MemFault stays 1 across a subsequent good load and clears only on reset.
- Reset asserted in the 2nd ACCESS cycle, then ack driven one cycle later. Required: req=0 and StallPipe=0 after the edge, no capture, MemFault=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory: runs one req/ack
// transaction per load/store, stalls upstream, bubbles MEM/WB, flags timeouts.
module mem_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadMEM,
   input  logic        MemWriteMEM,
   input  logic [31:0] AddrMEM,
   input  logic [31:0] WriteDataMEM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] ReadDataMEM,
   output logic        StallPipe,
   output logic        BubbleWB,
   output logic        MemFault
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       op_p0;
   logic       timeout_hit;
   logic [7:0] cnt;

   // A store wins when both request bits are set, so op presence is a plain OR.
   assign op_p0       = MemReadMEM | MemWriteMEM;
   assign timeout_hit = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (op_p0) state_nxt = ACCESS;
         ACCESS:  if (dmem_ack || timeout_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Stall rises combinationally the cycle an op shows up; reset overrides it.
   always_comb begin
      StallPipe = 1'b0;
      if (!reset)
         StallPipe = (state == ACCESS) || ((state == IDLE) && op_p0);
      BubbleWB = StallPipe;
   end

   // ---- memory port / result registers (ack beats timeout on the last cycle)
   always_ff @(posedge clk) begin
      if (reset) begin
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= '0;
         dmem_wdata  <= '0;
         ReadDataMEM <= '0;
         MemFault    <= 1'b0;
         cnt         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_p0) begin
                  dmem_addr  <= AddrMEM;
                  dmem_wdata <= WriteDataMEM;
                  dmem_we    <= MemWriteMEM;
                  dmem_req   <= 1'b1;
                  cnt        <= '0;
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  if (!dmem_we) ReadDataMEM <= dmem_rdata;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end else if (timeout_hit) begin
                  MemFault <= 1'b1;
                  if (!dmem_we) ReadDataMEM <= '0;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_mem_access_ctrl;
   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemReadMEM = 1'b0, MemWriteMEM = 1'b0, dmem_ack = 1'b0;
   logic [31:0] AddrMEM = '0, WriteDataMEM = '0, dmem_rdata = '0;
   logic        dmem_req, dmem_we, StallPipe, BubbleWB, MemFault;
   logic [31:0] dmem_addr, dmem_wdata, ReadDataMEM;

   mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .MemReadMEM(MemReadMEM), .MemWriteMEM(MemWriteMEM),
      .AddrMEM(AddrMEM), .WriteDataMEM(WriteDataMEM),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .ReadDataMEM(ReadDataMEM), .StallPipe(StallPipe),
      .BubbleWB(BubbleWB), .MemFault(MemFault)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a transaction is either in flight (with its age in
   // request cycles) or just retired (one cycle where the result is handed on).
   bit          m_txn = 0, m_post = 0;
   int          m_age = 0;
   logic        m_req = 0, m_we = 0, m_fault = 0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rd = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_txn = 0; m_post = 0; m_age = 0;
         m_req = 0; m_we = 0; m_fault = 0;
         m_addr = '0; m_wdata = '0; m_rd = '0;
      end else if (m_txn) begin
         if (dmem_ack) begin
            if (!m_we) m_rd = dmem_rdata;
            m_txn = 0; m_post = 1; m_req = 0; m_we = 0;
         end else if (m_age == TIMEOUT) begin
            m_fault = 1;
            if (!m_we) m_rd = '0;
            m_txn = 0; m_post = 1; m_req = 0; m_we = 0;
         end else begin
            m_age++;
         end
      end else if (m_post) begin
         m_post = 0;
      end else if (MemReadMEM | MemWriteMEM) begin
         m_txn = 1; m_age = 1; m_req = 1; m_we = MemWriteMEM;
         m_addr = AddrMEM; m_wdata = WriteDataMEM;
      end
   end

   always @(negedge clk) begin
      logic exp_stall;
      exp_stall = !reset && (m_txn || (!m_post && (MemReadMEM | MemWriteMEM)));
      chk("m_stall", 32'(StallPipe), 32'(exp_stall));
      chk("m_bubble", 32'(BubbleWB), 32'(exp_stall));
      chk("m_req", 32'(dmem_req), 32'(m_req));
      chk("m_we", 32'(dmem_we), 32'(m_we));
      chk("m_addr", dmem_addr, m_addr);
      chk("m_wdata", dmem_wdata, m_wdata);
      chk("m_rdata", ReadDataMEM, m_rd);
      chk("m_fault", 32'(MemFault), 32'(m_fault));
   end

   task automatic next();
      @(posedge clk); #1;
   endtask

   // Starts just after an edge with the controller idle; ends at the falling
   // edge of the first unstalled cycle. w<0 means memory never acknowledges.
   task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int w, input logic [31:0] rdat,
                         output int req_n, output int stall_n, output logic we_seen);
      bit done;
      done = 0; req_n = 0; stall_n = 0; we_seen = 0;
      MemReadMEM = rd; MemWriteMEM = wr; AddrMEM = a; WriteDataMEM = d;
      for (int c = 0; c < 64 && !done; c++) begin
         dmem_ack   = (w >= 0) && (c == w + 1);
         dmem_rdata = dmem_ack ? rdat : 32'hDEAD_BEEF;
         @(negedge clk);
         if (StallPipe) stall_n++;
         if (dmem_req)  req_n++;
         if (dmem_we)   we_seen = 1;
         if (c > 0 && !StallPipe) done = 1;
         else next();
      end
      dmem_ack = 0;
      if (!done) begin
         tests++; fails++;
         $display("FAIL op_bound: got no completion expected completion within 64 cycles");
      end
   endtask

   initial begin
      int   rq, st;
      logic wes;

      // Reset with a pending load and a toggling ack: nothing may leak out.
      MemReadMEM = 1;
      for (int i = 0; i < 2; i++) begin
         dmem_ack = (i == 0);
         @(negedge clk);
         chk("rst_stall", 32'(StallPipe), 32'd0);
         chk("rst_req", 32'(dmem_req), 32'd0);
         chk("rst_rdata", ReadDataMEM, 32'd0);
         chk("rst_fault", 32'(MemFault), 32'd0);
         next();
      end
      reset = 0; MemReadMEM = 0; dmem_ack = 0;
      @(negedge clk);
      next();

      // Zero-wait load
      run_op(1, 0, 32'h100, 0, 0, 32'h1234_5678, rq, st, wes);
      chk("ld0_req_cycles", rq, 1);
      chk("ld0_stall_cycles", st, 2);
      chk("ld0_rdata", ReadDataMEM, 32'h1234_5678);
      chk("ld0_addr", dmem_addr, 32'h100);
      next();

      // Store with 3 wait cycles; ack lands on the last allowed cycle
      run_op(0, 1, 32'h200, 32'hCAFE_F00D, 3, 0, rq, st, wes);
      chk("st3_req_cycles", rq, 4);
      chk("st3_stall_cycles", st, 5);
      chk("st3_we", 32'(wes), 32'd1);
      chk("st3_rdata_kept", ReadDataMEM, 32'h1234_5678);
      chk("st3_wdata", dmem_wdata, 32'hCAFE_F00D);
      chk("st3_nofault", 32'(MemFault), 32'd0);
      next();
      MemWriteMEM = 0;
      @(negedge clk);
      chk("idle_stall", 32'(StallPipe), 32'd0);
      next();

      // Back-to-back load, store, then dual-bit op (treated as store)
      run_op(1, 0, 32'h104, 0, 0, 32'h0BAD_CAFE, rq, st, wes);
      chk("b2b_ld_stall", st, 2);
      next();
      run_op(0, 1, 32'h108, 32'h11, 0, 0, rq, st, wes);
      chk("b2b_st_stall", st, 2);
      chk("b2b_st_rdata", ReadDataMEM, 32'h0BAD_CAFE);
      next();
      run_op(1, 1, 32'h10C, 32'h22, 0, 32'h9999_9999, rq, st, wes);
      chk("dual_stall", st, 2);
      chk("dual_we", 32'(wes), 32'd1);
      chk("dual_rdata", ReadDataMEM, 32'h0BAD_CAFE);
      next();
      MemReadMEM = 0; MemWriteMEM = 0;

      // Timeout on a load
      run_op(1, 0, 32'h400, 0, -1, 0, rq, st, wes);
      chk("to_req_cycles", rq, TIMEOUT);
      chk("to_stall_cycles", st, TIMEOUT + 1);
      chk("to_fault", 32'(MemFault), 32'd1);
      chk("to_rdata", ReadDataMEM, 32'd0);
      next();
      MemReadMEM = 0;
      @(negedge clk);
      chk("to_fault_sticky", 32'(MemFault), 32'd1);
      next();

      // Good load after a fault
      run_op(1, 0, 32'h500, 0, 1, 32'hA5A5_A5A5, rq, st, wes);
      chk("post_ld_stall", st, 3);
      chk("post_ld_rdata", ReadDataMEM, 32'hA5A5_A5A5);
      chk("post_ld_fault", 32'(MemFault), 32'd1);
      next();
      MemReadMEM = 0;

      // Reset in the 2nd access cycle, late ack afterwards
      next();
      MemReadMEM = 1; AddrMEM = 32'h600;
      next();
      next();
      reset = 1;
      @(negedge clk);
      chk("ra_stall_forced", 32'(StallPipe), 32'd0);
      next();
      reset = 0; MemReadMEM = 0; dmem_ack = 1; dmem_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("ra_req", 32'(dmem_req), 32'd0);
      chk("ra_stall", 32'(StallPipe), 32'd0);
      chk("ra_fault", 32'(MemFault), 32'd0);
      chk("ra_rdata", ReadDataMEM, 32'd0);
      next();
      dmem_ack = 0;
      @(negedge clk);
      chk("ra_late_rdata", ReadDataMEM, 32'd0);
      chk("ra_late_req", 32'(dmem_req), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
